// File: rtl/ram_arb_pkg.sv
// Shared types and default sizes for the frame-buffer RAM port arbiter.
package ram_arb_pkg;

    typedef enum logic [1:0] {
        REQ_NONE,
        REQ_VGA,
        REQ_WR,
        REQ_RD
    } requester_t;

    localparam int DEF_ADDR_BITS  = 21;
    localparam int DEF_DATA_WIDTH = 8;

endpackage

// File: rtl/starve_counter.sv
// Saturating wait counter: counts cycles a request waits ungranted, flags MAX_WAIT-1.
module starve_counter #(
    parameter int MAX_WAIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic req,
    input  logic gnt,
    output logic sat
);

    localparam logic [7:0] SAT_VAL = 8'(MAX_WAIT - 1);

    logic [7:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (!req || gnt) begin
            cnt <= '0;
        end else if (cnt != SAT_VAL) begin
            cnt <= cnt + 8'd1;
        end
    end

    // Gated with req so a stale count never wins a grant for an idle requester.
    assign sat = req && (cnt == SAT_VAL);

endmodule

// File: rtl/ram_port_arbiter.sv
// Single-port RAM arbiter: VGA fetch, serial write and serial dump share one port.
// Optional starvation guard enabled by defining ARB_STARVE_GUARD_EN.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_BITS  = DEF_ADDR_BITS,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int MAX_WAIT   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  vga_req,
    input  logic [ADDR_BITS-1:0]  vga_addr,
    output logic                  vga_gnt,
    output logic                  vga_rvalid,
    input  logic                  wr_req,
    input  logic [ADDR_BITS-1:0]  wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_gnt,
    input  logic                  rd_req,
    input  logic [ADDR_BITS-1:0]  rd_addr,
    output logic                  rd_gnt,
    output logic                  rd_rvalid,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [ADDR_BITS-1:0]  ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    output logic                  ram_we,
    output logic                  ram_re,
    input  logic [DATA_WIDTH-1:0] ram_rdata
);

    if (MAX_WAIT < 2 || MAX_WAIT > 255) begin : g_bad_max_wait
        $error("MAX_WAIT must be in 2..255");
    end

    requester_t winner;
    logic       rr_ptr;      // 0: wr favoured on a tie, 1: rd favoured
    logic       wr_sat;
    logic       rd_sat;
    logic       vga_vld_p1;
    logic       rd_vld_p1;

`ifdef ARB_STARVE_GUARD_EN
    starve_counter #(.MAX_WAIT(MAX_WAIT)) u_wr_wait (
        .clk (clk),
        .rst (rst),
        .req (wr_req),
        .gnt (wr_gnt),
        .sat (wr_sat)
    );

    starve_counter #(.MAX_WAIT(MAX_WAIT)) u_rd_wait (
        .clk (clk),
        .rst (rst),
        .req (rd_req),
        .gnt (rd_gnt),
        .sat (rd_sat)
    );
`else
    assign wr_sat = 1'b0;
    assign rd_sat = 1'b0;
`endif

    // Arbitration: starved wr/rd over VGA, VGA over wr/rd, round-robin between wr and rd.
    always_comb begin
        winner = REQ_NONE;
        if (rst) begin
            winner = REQ_NONE;
        end else if (wr_sat && rd_sat) begin
            winner = rr_ptr ? REQ_RD : REQ_WR;
        end else if (wr_sat) begin
            winner = REQ_WR;
        end else if (rd_sat) begin
            winner = REQ_RD;
        end else if (vga_req) begin
            winner = REQ_VGA;
        end else if (wr_req && rd_req) begin
            winner = rr_ptr ? REQ_RD : REQ_WR;
        end else if (wr_req) begin
            winner = REQ_WR;
        end else if (rd_req) begin
            winner = REQ_RD;
        end
    end

    always_comb begin
        vga_gnt  = 1'b0;
        wr_gnt   = 1'b0;
        rd_gnt   = 1'b0;
        ram_we   = 1'b0;
        ram_re   = 1'b0;
        ram_addr = '0;
        case (winner)
            REQ_VGA: begin
                vga_gnt  = 1'b1;
                ram_re   = 1'b1;
                ram_addr = vga_addr;
            end
            REQ_WR: begin
                wr_gnt   = 1'b1;
                ram_we   = 1'b1;
                ram_addr = wr_addr;
            end
            REQ_RD: begin
                rd_gnt   = 1'b1;
                ram_re   = 1'b1;
                ram_addr = rd_addr;
            end
            default: ;
        endcase
    end

    assign ram_wdata = wr_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= 1'b0;
        end else if (winner == REQ_WR || winner == REQ_RD) begin
            rr_ptr <= ~rr_ptr;
        end
    end

    // Stage p1: read response returns one cycle after the grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            vga_vld_p1 <= 1'b0;
            rd_vld_p1  <= 1'b0;
        end else begin
            vga_vld_p1 <= (winner == REQ_VGA);
            rd_vld_p1  <= (winner == REQ_RD);
        end
    end

    // A response in flight when rst rises is dropped in that same cycle.
    assign vga_rvalid = vga_vld_p1 && !rst;
    assign rd_rvalid  = rd_vld_p1 && !rst;
    assign rdata      = ram_rdata;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a small synchronous RAM model.
module tb_ram_port_arbiter;

    localparam int AW = 21;
    localparam int DW = 8;
`ifdef ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          vga_req, wr_req, rd_req;
    logic [AW-1:0] vga_addr, wr_addr, rd_addr;
    logic [DW-1:0] wr_data;
    logic          vga_gnt, vga_rvalid, wr_gnt, rd_gnt, rd_rvalid;
    logic [DW-1:0] rdata, ram_wdata;
    logic [AW-1:0] ram_addr;
    logic          ram_we, ram_re;
    logic [DW-1:0] ram_rdata = '0;

    int checks = 0;
    int errors = 0;

    ram_port_arbiter #(.ADDR_BITS(AW), .DATA_WIDTH(DW), .MAX_WAIT(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .vga_req    (vga_req),
        .vga_addr   (vga_addr),
        .vga_gnt    (vga_gnt),
        .vga_rvalid (vga_rvalid),
        .wr_req     (wr_req),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_gnt     (wr_gnt),
        .rd_req     (rd_req),
        .rd_addr    (rd_addr),
        .rd_gnt     (rd_gnt),
        .rd_rvalid  (rd_rvalid),
        .rdata      (rdata),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_we     (ram_we),
        .ram_re     (ram_re),
        .ram_rdata  (ram_rdata)
    );

    always #5 clk = ~clk;

    // RAM model: unwritten words read as addr^0x5A; read returns pre-write data.
    logic [DW-1:0] mem [0:255];
    logic [255:0]  written = '0;

    always @(posedge clk) begin
        if (ram_re)
            ram_rdata <= written[ram_addr[7:0]] ? mem[ram_addr[7:0]] : (ram_addr[7:0] ^ 8'h5A);
        if (ram_we) begin
            mem[ram_addr[7:0]]     <= ram_wdata;
            written[ram_addr[7:0]] <= 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        vga_req = 1'b1; wr_req = 1'b1; rd_req = 1'b1;
        vga_addr = 21'h10; wr_addr = 21'h5; rd_addr = 21'h7; wr_data = 8'hA5;
        next_cycle();
        next_cycle();
        #1;
        chk("rst_gnts", {29'd0, vga_gnt, wr_gnt, rd_gnt}, 32'd0);
        chk("rst_ram_ctl", {30'd0, ram_we, ram_re}, 32'd0);
        chk("rst_rvalid", {30'd0, vga_rvalid, rd_rvalid}, 32'd0);

        // C0: three-way contention, VGA wins
        next_cycle(); rst = 1'b0; #1;
        chk("c0_gnts", {29'd0, vga_gnt, wr_gnt, rd_gnt}, 32'b100);
        chk("c0_ram_re", {31'd0, ram_re}, 32'd1);
        chk("c0_ram_we", {31'd0, ram_we}, 32'd0);
        chk("c0_addr", 32'(ram_addr), 32'h10);

        // C1..C4: wr/rd alternation starting with wr
        next_cycle(); vga_req = 1'b0; #1;
        chk("c1_vga_rvalid", {31'd0, vga_rvalid}, 32'd1);
        chk("c1_rdata", 32'(rdata), 32'h4A);
        chk("c1_gnts", {29'd0, vga_gnt, wr_gnt, rd_gnt}, 32'b010);
        chk("c1_we_addr", {ram_we, 10'd0, ram_addr}, {1'b1, 10'd0, 21'h5});
        chk("c1_wdata", 32'(ram_wdata), 32'hA5);
        next_cycle(); #1;
        chk("c2_gnts", {29'd0, vga_gnt, wr_gnt, rd_gnt}, 32'b001);
        chk("c2_re_addr", {ram_re, 10'd0, ram_addr}, {1'b1, 10'd0, 21'h7});
        next_cycle(); #1;
        chk("c3_gnts", {29'd0, vga_gnt, wr_gnt, rd_gnt}, 32'b010);
        chk("c3_rd_rvalid", {31'd0, rd_rvalid}, 32'd1);
        chk("c3_rdata", 32'(rdata), 32'h5D);
        next_cycle(); #1;
        chk("c4_gnts", {29'd0, vga_gnt, wr_gnt, rd_gnt}, 32'b001);

        // C5: idle port
        next_cycle(); wr_req = 1'b0; rd_req = 1'b0; wr_data = 8'h3C; #1;
        chk("c5_idle_ctl", {30'd0, ram_we, ram_re}, 32'd0);
        chk("c5_idle_addr", 32'(ram_addr), 32'd0);
        chk("c5_wdata_pass", 32'(ram_wdata), 32'h3C);
        chk("c5_rd_rvalid", {31'd0, rd_rvalid}, 32'd1);

        // C6..C7: read back written A5
        next_cycle(); rd_req = 1'b1; rd_addr = 21'h5; #1;
        chk("c6_rd_gnt", {31'd0, rd_gnt}, 32'd1);
        chk("c6_addr", 32'(ram_addr), 32'h5);
        next_cycle(); rd_req = 1'b0; #1;
        chk("c7_rd_rvalid", {30'd0, vga_rvalid, rd_rvalid}, 32'b01);
        chk("c7_rdata", 32'(rdata), 32'hA5);

        // C8..C11: read then write to the same word
        next_cycle(); rd_req = 1'b1; rd_addr = 21'h20; #1;
        chk("c8_rd_gnt", {31'd0, rd_gnt}, 32'd1);
        next_cycle(); rd_req = 1'b0; wr_req = 1'b1; wr_addr = 21'h20; wr_data = 8'h77; #1;
        chk("c9_wr_gnt", {31'd0, wr_gnt}, 32'd1);
        chk("c9_pre_write", {rd_rvalid, 23'd0, rdata}, {1'b1, 23'd0, 8'h7A});
        next_cycle(); wr_req = 1'b0; rd_req = 1'b1; #1;
        chk("c10_rd_gnt", {31'd0, rd_gnt}, 32'd1);
        next_cycle(); rd_req = 1'b0; #1;
        chk("c11_post_write", {rd_rvalid, 23'd0, rdata}, {1'b1, 23'd0, 8'h77});

        // C12..C15: VGA held against a waiting write
        next_cycle(); vga_req = 1'b1; vga_addr = 21'h40; wr_req = 1'b1; wr_addr = 21'h30; wr_data = 8'h11; #1;
        chk("c12_gnts", {29'd0, vga_gnt, wr_gnt, rd_gnt}, 32'b100);
        next_cycle(); #1;
        chk("c13_gnts", {29'd0, vga_gnt, wr_gnt, rd_gnt}, 32'b100);
        next_cycle(); #1;
        chk("c14_gnts", {29'd0, vga_gnt, wr_gnt, rd_gnt}, 32'b100);
        next_cycle(); #1;
        chk("c15_gnts", {29'd0, vga_gnt, wr_gnt, rd_gnt}, GUARD ? 32'b010 : 32'b100);
        chk("c15_addr", 32'(ram_addr), GUARD ? 32'h30 : 32'h40);
        chk("c15_vga_data", {vga_rvalid, 23'd0, rdata}, {1'b1, 23'd0, 8'h1A});

        // C16..C18: settle pointer to favour rd before reset
        next_cycle(); vga_req = 1'b0; wr_req = !GUARD; #1;
        chk("c16_wr_gnt", {31'd0, wr_gnt}, GUARD ? 32'd0 : 32'd1);
        next_cycle(); wr_req = 1'b1; wr_addr = 21'h31; wr_data = 8'h22; #1;
        chk("c17_wr_gnt", {31'd0, wr_gnt}, 32'd1);
        next_cycle(); wr_req = 1'b0; rd_req = 1'b1; rd_addr = 21'h5; #1;
        chk("c18_rd_gnt", {31'd0, rd_gnt}, 32'd1);

        // C19..C20: reset drops the pending read and blocks everything
        next_cycle(); rst = 1'b1; rd_req = 1'b0; #1;
        chk("c19_rd_rvalid", {31'd0, rd_rvalid}, 32'd0);
        chk("c19_gnts", {29'd0, vga_gnt, wr_gnt, rd_gnt}, 32'd0);
        next_cycle(); vga_req = 1'b1; wr_req = 1'b1; rd_req = 1'b1; #1;
        chk("c20_all_zero", {27'd0, vga_gnt, wr_gnt, rd_gnt, ram_we, ram_re}, 32'd0);
        chk("c20_rvalid", {30'd0, vga_rvalid, rd_rvalid}, 32'd0);
        chk("c20_addr", 32'(ram_addr), 32'd0);

        // C21..C22: pointer back to wr after reset
        next_cycle(); rst = 1'b0; vga_req = 1'b0; #1;
        chk("c21_gnts", {29'd0, vga_gnt, wr_gnt, rd_gnt}, 32'b010);
        chk("c21_rd_rvalid", {31'd0, rd_rvalid}, 32'd0);
        next_cycle(); #1;
        chk("c22_gnts", {29'd0, vga_gnt, wr_gnt, rd_gnt}, 32'b001);

        next_cycle(); wr_req = 1'b0; rd_req = 1'b0;
        next_cycle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
